word_round_controller: RTL and testbench
========================================

Name: word_round_controller

Overview:
- Sequencer for the typing game. Fetches 4-letter words (four 5-bit letter codes, 20 bits) from a registered word ROM and presents them to the keystroke checker.
- Clears the checker at the start of each word and counts completed words as score.
- Enforces a per-word time limit and declares the game won or lost.
- Sits between the word ROM, the keystroke checker and the display/score logic.

Parameters:
- NUM_WORDS, 16, number of ROM entries. Need not be a power of two.
- ADDR_W, 4, word_addr width. Must satisfy 2^ADDR_W >= NUM_WORDS.
- TIMEOUT_CYCLES, 100000000, clock cycles allowed per word. Must be >= 1.
- TIMER_W, 32, timer width. Must hold TIMEOUT_CYCLES-1.
- SCORE_W, 8, score width.
- WIN_SCORE, 10, score that wins the game. Must satisfy 1 <= WIN_SCORE <= 2^SCORE_W-1.

Ports:
- clk, in, 1, system clock. All logic is on the rising edge.
- reset, in, 1, asynchronous, active-high. Forces all state and outputs to reset values immediately.
- start, in, 1, begin or restart the game. Sampled only in IDLE, WON and LOST.
- word_addr, out, ADDR_W, word ROM address.
- word_data, in, 20, ROM word. Valid one cycle after word_addr changes.
- current_word, out, 20, word presented to the checker. Bits [19:15] are the first letter.
- checker_clr, out, 1, one-cycle pulse that clears checker state.
- word_complete, in, 1, checker "word done" flag. It is a level that may stay high until the next correct keystroke.
- mistake, in, 1, checker wrong-key flag (level).
- score, out, SCORE_W, count of words completed.
- state, out, 3, current FSM state: IDLE=0, FETCH=1, LOAD=2, PLAY=3, WON=4, LOST=5.
- game_won, out, 1, high while in WON.
- game_lost, out, 1, high while in LOST.

Behaviour:
- Reset values:
  - state = IDLE
  - word_addr = 0
  - current_word = 0
  - checker_clr = 0
  - score = 0
  - timer = 0
  - wc_prev = 0
  - game_won = 0
  - game_lost = 0
- IDLE:
  - start=1 -> score<=0, word_addr<=0, go to FETCH.
  - Otherwise hold.
- FETCH: one wait cycle covering ROM latency, then go to LOAD.
- LOAD:
  - current_word<=word_data.
  - checker_clr=1 for this cycle only (combinational on state==LOAD).
  - timer<=TIMEOUT_CYCLES-1.
  - Go to PLAY.
- PLAY: timer decrements by 1 every cycle. Events are evaluated in this priority order:
  1. mistake=1 -> LOST.
  2. Rising edge of word_complete (word_complete=1 and wc_prev=0):
     - score<=score+1.
     - If score+1==WIN_SCORE -> WON.
     - Otherwise word_addr<=(word_addr==NUM_WORDS-1)?0:word_addr+1 and go to FETCH.
  3. timer==0 -> LOST.
- wc_prev<=word_complete every cycle in every state. A level held high across LOAD and into PLAY therefore never scores twice.
- Simultaneous events in PLAY:
  - mistake together with a word_complete edge -> LOST, score unchanged.
  - A word_complete edge in the same cycle as timer==0 -> counts as completion.
- WON / LOST:
  - Hold; game_won/game_lost are registered and high for the whole state.
  - score is held for display.
  - start=1 -> clear both flags, score<=0, word_addr<=0, go to FETCH.
- start is ignored in FETCH, LOAD and PLAY.
- Latency: from start sampled high to the first PLAY cycle is 3 cycles (FETCH, LOAD, PLAY).
- Word-to-word gap after a completion edge is 2 cycles (FETCH, LOAD).
- score never overflows, because the game ends at WIN_SCORE.
- Reset asserted mid-game returns to IDLE asynchronously. No checker_clr pulse is issued until the next LOAD.

Test Plan (bench uses NUM_WORDS=4, ADDR_W=2, TIMEOUT_CYCLES=20, WIN_SCORE=3; ROM[i]=20'h0_1234+i):
- Reset, then start pulse:
  - state goes 0 -> 1 -> 2 -> 3 on consecutive edges.
  - checker_clr high exactly during LOAD.
  - current_word=20'h01234, score=0.
- Pulse word_complete three times, 5 PLAY cycles after each LOAD:
  - score goes 1 -> 2 -> 3.
  - word_addr goes 0 -> 1 -> 2.
  - Reaches WON with game_won=1 and score=3 held.
  - Then start gives score=0, word_addr=0, FETCH.
- Hold word_complete high for 10 cycles after one completion:
  - score increments only once.
  - No second completion is counted on the next word until word_complete falls and rises again.
- No input in PLAY: LOST is entered on the edge after the 20th PLAY cycle; game_lost=1 and score is unchanged.
- mistake and a word_complete rising edge in the same PLAY cycle: LOST, score not incremented.
- Complete 4 words with WIN_SCORE raised to 6: word_addr wraps 3 -> 0 and current_word=20'h01234 again.
- Assert reset during PLAY: all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/word_round_controller_if.sv
// Bundle between the round controller and the word ROM, keystroke checker and display/score logic.
// The master side is the controller. The slave side is the surrounding game logic.
interface word_round_controller_if #(
  parameter int ADDR_W  = 4,
  parameter int SCORE_W = 8
);
  logic               start;
  logic [ADDR_W-1:0]  word_addr;
  logic [19:0]        word_data;
  logic [19:0]        current_word;
  logic               checker_clr;
  logic               word_complete;
  logic               mistake;
  logic [SCORE_W-1:0] score;
  logic [2:0]         state;
  logic               game_won;
  logic               game_lost;

  modport master (
    input  start, word_data, word_complete, mistake,
    output word_addr, current_word, checker_clr, score, state, game_won, game_lost
  );

  modport slave (
    output start, word_data, word_complete, mistake,
    input  word_addr, current_word, checker_clr, score, state, game_won, game_lost
  );
endinterface

// File: rtl/word_round_controller.sv
// Typing-game round sequencer: fetches words from a registered ROM, times each word,
// counts completions as score and declares the game won or lost.
module word_round_controller #(
  parameter int NUM_WORDS      = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TIMER_W        = 32,
  parameter int SCORE_W        = 8,
  parameter int WIN_SCORE      = 10
) (
  input logic                    clk,
  input logic                    reset,
  word_round_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    WON   = 3'd4,
    LOST  = 3'd5
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [SCORE_W-1:0] WIN_VALUE  = SCORE_W'(WIN_SCORE);

  state_t             state_q;
  logic [ADDR_W-1:0]  word_addr_q;
  logic [19:0]        current_word_q;
  logic [SCORE_W-1:0] score_q;
  logic [TIMER_W-1:0] timer_q;
  logic               wc_prev_q;
  logic               game_won_q;
  logic               game_lost_q;

  logic [SCORE_W-1:0] score_d;
  logic [ADDR_W-1:0]  word_addr_d;
  logic               wcEdge;

  assign score_d     = score_q + 1'b1;
  assign word_addr_d = (word_addr_q == LAST_ADDR) ? '0 : word_addr_q + 1'b1;
  // A level held high from the previous word must not score again, so only rising edges count
  assign wcEdge      = bus.word_complete & ~wc_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      word_addr_q    <= '0;
      current_word_q <= '0;
      score_q        <= '0;
      timer_q        <= '0;
      wc_prev_q      <= 1'b0;
      game_won_q     <= 1'b0;
      game_lost_q    <= 1'b0;
    end else begin
      wc_prev_q <= bus.word_complete;
      case (state_q)
        IDLE, WON, LOST: begin
          if (bus.start) begin
            score_q     <= '0;
            word_addr_q <= '0;
            game_won_q  <= 1'b0;
            game_lost_q <= 1'b0;
            state_q     <= FETCH;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          current_word_q <= bus.word_data;
          timer_q        <= TIMER_LOAD;
          state_q        <= PLAY;
        end
        PLAY: begin
          if (timer_q != '0) timer_q <= timer_q - 1'b1;
          // Mistake beats completion, and completion beats an expiring timer
          if (bus.mistake) begin
            game_lost_q <= 1'b1;
            state_q     <= LOST;
          end else if (wcEdge) begin
            score_q <= score_d;
            if (score_d == WIN_VALUE) begin
              game_won_q <= 1'b1;
              state_q    <= WON;
            end else begin
              word_addr_q <= word_addr_d;
              state_q     <= FETCH;
            end
          end else if (timer_q == '0) begin
            game_lost_q <= 1'b1;
            state_q     <= LOST;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.word_addr    = word_addr_q;
  assign bus.current_word = current_word_q;
  assign bus.checker_clr  = (state_q == LOAD);
  assign bus.score        = score_q;
  assign bus.state        = state_q;
  assign bus.game_won     = game_won_q;
  assign bus.game_lost    = game_lost_q;

endmodule

// File: tb/tb_word_round_controller.sv
// Directed bench for word_round_controller: one instance with WIN_SCORE=3 for the main game flow,
// a second with WIN_SCORE=6 to exercise word address wrap-around.
module tb_word_round_controller;

  logic clk;
  logic reset;

  word_round_controller_if #(.ADDR_W(2), .SCORE_W(8)) a ();
  word_round_controller_if #(.ADDR_W(2), .SCORE_W(8)) b ();

  word_round_controller #(
    .NUM_WORDS(4), .ADDR_W(2), .TIMEOUT_CYCLES(20), .TIMER_W(32), .SCORE_W(8), .WIN_SCORE(3)
  ) dutA (.clk(clk), .reset(reset), .bus(a.master));

  word_round_controller #(
    .NUM_WORDS(4), .ADDR_W(2), .TIMEOUT_CYCLES(20), .TIMER_W(32), .SCORE_W(8), .WIN_SCORE(6)
  ) dutB (.clk(clk), .reset(reset), .bus(b.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered word ROM models: ROM[i] = 20'h01234 + i
  always @(posedge clk) a.word_data <= 20'h01234 + 20'(a.word_addr);
  always @(posedge clk) b.word_data <= 20'h01234 + 20'(b.word_addr);

  int passCount  = 0;
  int checkCount = 0;
  int unsigned expQ[$];
  string tagQ[$];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pushExpect(input string tag, input int unsigned val);
    tagQ.push_back(tag);
    expQ.push_back(val);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    if (expQ.size() == 0) begin
      checkCount++;
      $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      checkOutput(tagQ.pop_front(), obs, expQ.pop_front());
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic start, input logic wc, input logic mis);
    if (sel == 1'b0) begin
      a.start = start; a.word_complete = wc; a.mistake = mis;
    end else begin
      b.start = start; b.word_complete = wc; b.mistake = mis;
    end
  endtask

  // Drives one word_complete rising edge on instance A and scores the resulting transition
  task automatic completeWordA(input string tag, input int expScore, input int expAddr, input int expState);
    pushExpect({tag, "_score"}, expScore);
    pushExpect({tag, "_addr"}, expAddr);
    pushExpect({tag, "_state"}, expState);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    popCheck(a.score);
    popCheck(a.word_addr);
    popCheck(a.state);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("rst_state", a.state, 0);
    checkOutput("rst_addr", a.word_addr, 0);
    checkOutput("rst_word", a.current_word, 0);
    checkOutput("rst_clr", a.checker_clr, 0);
    checkOutput("rst_score", a.score, 0);
    checkOutput("rst_won", a.game_won, 0);
    checkOutput("rst_lost", a.game_lost, 0);
    reset = 1'b0;
    tick(2);
    checkOutput("idle_hold", a.state, 0);

    // Start latency: FETCH, LOAD, PLAY on consecutive edges
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("start_fetch", a.state, 1);
    checkOutput("fetch_clr", a.checker_clr, 0);
    tick();
    checkOutput("load_state", a.state, 2);
    checkOutput("load_clr", a.checker_clr, 1);
    tick();
    checkOutput("play_state", a.state, 3);
    checkOutput("play_clr", a.checker_clr, 0);
    checkOutput("play_word0", a.current_word, 20'h01234);
    checkOutput("play_score0", a.score, 0);

    tick(4);
    completeWordA("win1", 1, 1, 1);
    tick(2);
    checkOutput("word1", a.current_word, 20'h01235);
    tick(4);
    completeWordA("win2", 2, 2, 1);
    tick(2);
    checkOutput("word2", a.current_word, 20'h01236);
    tick(4);
    completeWordA("win3", 3, 2, 4);
    checkOutput("won_flag", a.game_won, 1);
    tick(3);
    checkOutput("won_hold_state", a.state, 4);
    checkOutput("won_hold_score", a.score, 3);
    checkOutput("won_hold_flag", a.game_won, 1);

    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_state", a.state, 1);
    checkOutput("restart_score", a.score, 0);
    checkOutput("restart_addr", a.word_addr, 0);
    checkOutput("restart_won", a.game_won, 0);
    tick(2);

    // word_complete held high across the next word must score only once
    pushExpect("hold_score", 1);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    tick();
    popCheck(a.score);
    tick(9);
    checkOutput("hold_state", a.state, 3);
    checkOutput("hold_score_once", a.score, 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("hold_fall_score", a.score, 1);
    completeWordA("rearm", 2, 2, 1);
    tick(2);
    checkOutput("word_after_hold", a.current_word, 20'h01236);

    // Timeout: PLAY lasts exactly 20 cycles with no input
    tick(19);
    checkOutput("timeout_last_play", a.state, 3);
    tick();
    checkOutput("timeout_state", a.state, 5);
    checkOutput("timeout_lost", a.game_lost, 1);
    checkOutput("timeout_score", a.score, 2);
    checkOutput("timeout_won", a.game_won, 0);

    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("lost_restart", a.state, 1);
    checkOutput("lost_restart_flag", a.game_lost, 0);
    tick(2);

    // Mistake wins over a simultaneous completion edge
    applyStimulus(0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("mistake_state", a.state, 5);
    checkOutput("mistake_score", a.score, 0);
    checkOutput("mistake_lost", a.game_lost, 1);

    // Completion edge on the last timer cycle still counts
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    tick(2);
    tick(19);
    completeWordA("last_cycle", 1, 1, 1);
    tick(2);
    checkOutput("pre_reset_play", a.state, 3);

    // Asynchronous reset mid-PLAY, sampled between clock edges
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_state", a.state, 0);
    checkOutput("areset_addr", a.word_addr, 0);
    checkOutput("areset_word", a.current_word, 0);
    checkOutput("areset_clr", a.checker_clr, 0);
    checkOutput("areset_score", a.score, 0);
    checkOutput("areset_lost", a.game_lost, 0);
    #1;
    reset = 1'b0;
    tick(2);
    checkOutput("post_reset_idle", a.state, 0);

    // Address wrap on the WIN_SCORE=6 instance
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("wrap_word0", b.current_word, 20'h01234);
    for (int i = 1; i <= 4; i++) begin
      pushExpect($sformatf("wrap%0d_score", i), i);
      pushExpect($sformatf("wrap%0d_addr", i), i % 4);
      pushExpect($sformatf("wrap%0d_word", i), 20'h01234 + (i % 4));
      applyStimulus(1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1, 1'b0, 1'b0, 1'b0);
      popCheck(b.score);
      popCheck(b.word_addr);
      tick(2);
      popCheck(b.current_word);
    end
    checkOutput("wrap_state", b.state, 3);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
